// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {insn, pc} entries between fetch and decode.
// Registered-only ready/valid (no pass-through); flush drops every entry at the next edge.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INSN = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_insn,
    input  logic [31:0]                in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_insn,
    output logic [31:0]                out_pc,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      insn_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push;
    logic pop;

    // Handshakes are driven purely from occupancy, never from the opposite side.
    always_comb begin
        in_ready  = (count_q != CNT_W'(DEPTH));
        out_valid = (count_q != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    always_comb begin
        out_insn = NOP_INSN;
        out_pc   = '0;
        if (out_valid) begin
            out_insn = insn_mem[head_q];
            out_pc   = pc_mem[head_q];
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; only pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            insn_mem[tail_q] <= in_insn;
            pc_mem[tail_q]   <= in_pc;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based FIFO reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h00000013;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_insn;
    logic [31:0]      in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_insn;
    logic [31:0]      out_pc;
    logic             flush;
    logic [CNT_W-1:0] count;

    int vectors = 0;
    int errors  = 0;

    logic [63:0] model_q[$];
    logic [31:0] pc_gen = 32'h0;

    fetch_queue #(.DEPTH(DEPTH), .NOP_INSN(NOP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_insn   (in_insn),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_insn  (out_insn),
        .out_pc    (out_pc),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] e_insn;
        logic [31:0] e_pc;
        e_insn = NOP;
        e_pc   = 32'h0;
        if (model_q.size() != 0) begin
            e_insn = model_q[0][63:32];
            e_pc   = model_q[0][31:0];
        end
        check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        check("in_ready",  32'(in_ready),  32'(model_q.size() != DEPTH));
        check("count",     32'(count),     32'(model_q.size()));
        check("out_insn",  out_insn,       e_insn);
        check("out_pc",    out_pc,         e_pc);
    endtask

    // Called just after a falling edge; applies one clock of stimulus.
    task automatic step(input logic iv, input logic [31:0] insn, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        logic do_push;
        logic do_pop;
        in_valid  = iv;
        in_insn   = insn;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_outputs();
        do_push = iv && (model_q.size() < DEPTH);
        do_pop  = ordy && (model_q.size() > 0);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({insn, pc});
        end
        @(negedge clk);
    endtask

    task automatic push_seq(input logic ordy);
        step(1'b1, $urandom, pc_gen, ordy, 1'b0);
        pc_gen = pc_gen + 32'd4;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, $urandom, 32'hDEAD_BEEF, ordy, 1'b0);
    endtask

    task automatic mid_cycle_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_q.delete();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_count",     32'(count),     32'd0);
        check("rst_out_insn",  out_insn,       NOP);
        check("rst_out_pc",    out_pc,         32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_insn   = 32'h0;
        in_pc     = 32'h0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #1;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First push after reset, visible next cycle.
        step(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0);
        check("first_insn", out_insn, 32'h00500093);
        check("first_count", 32'(count), 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Fill to DEPTH, attempt a fifth push, then drain in order.
        pc_gen = 32'h0;
        for (int i = 0; i < DEPTH; i++) push_seq(1'b0);
        step(1'b1, 32'hFFFF_FFFF, 32'h0000_0100, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_pc", out_pc, 32'(i * 4));
            idle(1'b1);
        end
        idle(1'b0);

        // Steady state at count=2 with simultaneous push and pop.
        push_seq(1'b0);
        push_seq(1'b0);
        for (int i = 0; i < 10; i++) push_seq(1'b1);
        check("steady_count", 32'(count), 32'd2);

        // Flush at count=3 together with a push.
        push_seq(1'b0);
        step(1'b1, 32'h1234_5678, 32'h0000_0ABC, 1'b0, 1'b1);
        check("flush_insn", out_insn, NOP);
        idle(1'b0);

        // Empty queue, push and pop requested together.
        step(1'b1, 32'h00A00113, 32'h0000_0040, 1'b1, 1'b0);
        check("thru_pc", out_pc, 32'h0000_0040);
        idle(1'b0);

        // Fill, then asynchronous reset pulse mid-cycle.
        for (int i = 0; i < DEPTH; i++) push_seq(1'b0);
        mid_cycle_reset();
        push_seq(1'b0);
        idle(1'b1);

        // Randomized traffic with phases biased toward full and empty.
        for (int i = 0; i < 1500; i++) begin
            logic iv;
            logic ordy;
            logic fl;
            case ((i / 100) % 3)
                0:       begin iv = ($urandom_range(0, 3) != 0); ordy = ($urandom_range(0, 3) == 0); end
                1:       begin iv = ($urandom_range(0, 3) == 0); ordy = ($urandom_range(0, 3) != 0); end
                default: begin iv = $urandom_range(0, 1) == 1;   ordy = $urandom_range(0, 1) == 1; end
            endcase
            fl = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 300) == 0) begin
                mid_cycle_reset();
            end else begin
                step(iv, $urandom, pc_gen, ordy, fl);
                pc_gen = pc_gen + 32'd4;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of instruction entries; SHALL be a power of two, >= 2.
REQ-002 Parameter: NOP_INSN, default 32'h00000013, instruction word driven on out_insn when the queue is empty.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  fetch presents a valid instruction/PC pair.
REQ-006 in_ready  output  1  queue can accept an entry this cycle.
REQ-007 in_insn  input  32  fetched instruction word.
REQ-008 in_pc  input  32  PC of in_insn.
REQ-009 out_valid  output  1  head entry valid toward decode.
REQ-010 out_ready  input  1  decode consumes head entry this cycle.
REQ-011 out_insn  output  32  head instruction word, fed to the decoder's insn input.
REQ-012 out_pc  output  32  PC of head instruction.
REQ-013 flush  input  1  redirect (mispredict/jump); discard all entries.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH {insn, pc} entries with head (read) and tail (write) pointers of $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-016 push = in_valid & in_ready; pop = out_valid & out_ready; both SHALL be evaluated in the same cycle.
REQ-017 in_ready SHALL be (count != DEPTH); it SHALL NOT depend combinationally on out_ready (no pop-through when full).
REQ-018 out_valid SHALL be (count != 0); it SHALL NOT depend combinationally on in_valid (no push-through when empty).
REQ-019 When out_valid=1, out_insn/out_pc SHALL equal the head entry (combinational read); when empty, out_insn SHALL be NOP_INSN and out_pc SHALL be 0.
REQ-020 On push, the entry SHALL be written at tail and tail SHALL advance by 1; on pop, head SHALL advance by 1.
REQ-021 count next = count + push - pop; simultaneous push and pop SHALL leave count unchanged.
REQ-022 Latency: an entry pushed at edge N SHALL appear at the output no earlier than after edge N (visible in cycle N+1) when the queue was empty.
REQ-023 Ordering SHALL be strict FIFO; no entry SHALL be dropped or duplicated absent flush.
REQ-024 flush=1 SHALL, at the next edge, set head=tail=0 and count=0, overriding any push or pop that cycle; the flushed-cycle push SHALL be discarded.
REQ-025 During the flush cycle in_ready and out_valid SHALL retain their normal combinational values; decode ignores out_valid when flush is asserted.
REQ-026 Storage contents need not be cleared by reset or flush; only pointers and count.
REQ-027 in_valid deasserted, or in_insn changing while in_ready=0, SHALL have no effect on state.

Reset
REQ-028 rst_n=0 SHALL immediately (asynchronously) set head=0, tail=0, count=0, giving out_valid=0, in_ready=1, out_insn=NOP_INSN, out_pc=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries; the first push after release SHALL be the first entry output.
REQ-030 Deassertion of rst_n is synchronised externally; the block SHALL accept a push on the first rising edge after release.

Verification
REQ-031 Reset, then push {insn=32'h00500093, pc=0x0} with out_ready=0 -> next cycle out_valid=1, out_insn=32'h00500093, out_pc=0x0, count=1.
REQ-032 DEPTH=4, push PCs 0x0,0x4,0x8,0xC with out_ready=0 -> count=4, in_ready=0; a fifth in_valid is ignored; pops return PCs 0x0,0x4,0x8,0xC in order.
REQ-033 count=2, in_valid=1 and out_ready=1 for 10 cycles -> count stays 2, output PCs strictly sequential, pointers wrap past 3 without loss.
REQ-034 count=3, flush=1 together with in_valid=1 -> next cycle count=0, out_valid=0, out_insn=32'h00000013; pushed entry not output.
REQ-035 Full queue, rst_n pulsed low mid-cycle -> out_valid=0 and in_ready=1 before the next clock edge; count=0.
REQ-036 Empty queue, in_valid=1 and out_ready=1 same cycle -> out_valid=0 that cycle; entry output next cycle with count=1.
